// File: rtl/axi_writen_pkg.sv
// axi_writen shared types: FSM states and AXI response codes.
// Optional AXI_WRITEN_RESP_ERR_EN enables error accumulation in the top.
package axi_writen_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEATS,
        S_DRAIN,
        S_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] resp_max(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_writen_iter.sv
// Address iterator: loads a start value, then steps by INC_VAL
// (wrapping at 2^WIDTH) on each increment request.
module axi_writen_iter #(
    parameter int WIDTH   = 20,
    parameter int INC_VAL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic [WIDTH-1:0] init_val,
    input  logic             inc,
    output logic [WIDTH-1:0] val
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
        end else if (init) begin
            val <= init_val;
        end else if (inc) begin
            val <= val + WIDTH'(INC_VAL);
        end
    end

endmodule

// File: rtl/axi_writen.sv
// Splits one write burst into single-beat subordinate writes and folds
// the per-beat responses into one. Optional: AXI_WRITEN_RESP_ERR_EN.
module axi_writen
    import axi_writen_pkg::*;
#(
    parameter int STRIDE           = 2,
    parameter int AXI_ADDR_WIDTH   = 20,
    parameter int AXI_DATA_WIDTH   = 16,
    parameter int AXI_AWLENW_WIDTH = 8,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                        axi_clk,
    input  logic                        axi_resetn,
    input  logic [AXI_ADDR_WIDTH-1:0]   in_axi_awaddr,
    input  logic [AXI_AWLENW_WIDTH-1:0] in_axi_awlenw,
    input  logic                        in_axi_awvalid,
    output logic                        in_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   in_axi_wdata,
    input  logic                        in_axi_wlast,
    input  logic                        in_axi_wvalid,
    output logic                        in_axi_wready,
    output logic [1:0]                  in_axi_bresp,
    output logic                        in_axi_bvalid,
    input  logic                        in_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   out_axi_awaddr,
    output logic                        out_axi_awvalid,
    input  logic                        out_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   out_axi_wdata,
    output logic                        out_axi_wvalid,
    input  logic                        out_axi_wready,
    input  logic [1:0]                  out_axi_bresp,
    input  logic                        out_axi_bvalid,
    output logic                        out_axi_bready
);

    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    state_t                      state;
    logic [AXI_ADDR_WIDTH-1:0]   addr;
    logic [AXI_AWLENW_WIDTH-1:0] beats_left;
    logic [OW-1:0]               outstanding;
    logic [OW-1:0]               out_next;
    logic                        aw_hs;
    logic                        w_hs;
    logic                        b_hs;
    logic                        aw_clr;
    logic                        w_clr;
    logic                        drained;
    logic [1:0]                  resp_now;

    assign out_axi_bready = 1'b1;

    assign aw_hs  = in_axi_awvalid && in_axi_awready;
    assign aw_clr = !out_axi_awvalid || out_axi_awready;
    assign w_clr  = !out_axi_wvalid || out_axi_wready;

    assign in_axi_wready = (state == S_BEATS) && aw_clr && w_clr &&
                           (outstanding < OW'(MAX_OUTSTANDING));

    assign w_hs = in_axi_wvalid && in_axi_wready;
    // Stray responses after a mid-burst reset must not underflow the count
    assign b_hs = out_axi_bvalid && out_axi_bready && (outstanding != '0);

    assign out_next = outstanding + OW'(w_hs) - OW'(b_hs);
    assign drained  = (out_next == '0) && aw_clr && w_clr;

    axi_writen_iter #(
        .WIDTH   (AXI_ADDR_WIDTH),
        .INC_VAL (STRIDE)
    ) u_iter (
        .clk      (axi_clk),
        .rst_n    (axi_resetn),
        .init     (aw_hs),
        .init_val (in_axi_awaddr),
        .inc      (w_hs),
        .val      (addr)
    );

`ifdef AXI_WRITEN_RESP_ERR_EN
    logic [1:0] acc;
    logic [1:0] acc_next;
    logic       wlast_err;

    assign acc_next = b_hs ? resp_max(acc, out_axi_bresp) : acc;
    assign resp_now = wlast_err ? RESP_SLVERR : acc_next;

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            acc       <= RESP_OKAY;
            wlast_err <= 1'b0;
        end else if (aw_hs) begin
            acc       <= RESP_OKAY;
            wlast_err <= 1'b0;
        end else begin
            acc <= acc_next;
            if (w_hs && (in_axi_wlast != (beats_left == '0))) begin
                wlast_err <= 1'b1;
            end
        end
    end
`else
    logic unused_resp;
    assign unused_resp = &{1'b0, out_axi_bresp, in_axi_wlast};
    assign resp_now    = RESP_OKAY;
`endif

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state           <= S_IDLE;
            in_axi_awready  <= 1'b0;
            in_axi_bvalid   <= 1'b0;
            in_axi_bresp    <= RESP_OKAY;
            out_axi_awvalid <= 1'b0;
            out_axi_wvalid  <= 1'b0;
            out_axi_awaddr  <= '0;
            out_axi_wdata   <= '0;
            beats_left      <= '0;
            outstanding     <= '0;
        end else begin
            outstanding <= out_next;
            if (out_axi_awready) out_axi_awvalid <= 1'b0;
            if (out_axi_wready)  out_axi_wvalid  <= 1'b0;
            if (w_hs) begin
                out_axi_awaddr  <= addr;
                out_axi_wdata   <= in_axi_wdata;
                out_axi_awvalid <= 1'b1;
                out_axi_wvalid  <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    in_axi_awready <= 1'b1;
                    if (aw_hs) begin
                        in_axi_awready <= 1'b0;
                        beats_left     <= in_axi_awlenw;
                        state          <= S_BEATS;
                    end
                end
                S_BEATS: begin
                    if (w_hs) begin
                        if (beats_left == '0) state <= S_DRAIN;
                        else beats_left <= beats_left - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        in_axi_bvalid <= 1'b1;
                        in_axi_bresp  <= resp_now;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (in_axi_bready) begin
                        in_axi_bvalid  <= 1'b0;
                        in_axi_awready <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_writen.sv
// Scoreboard bench for axi_writen with a programmable-latency subordinate.
// Response expectations follow AXI_WRITEN_RESP_ERR_EN when it is defined.
module tb_axi_writen;

    logic        axi_clk = 1'b0;
    logic        axi_resetn;
    logic [19:0] in_axi_awaddr;
    logic [7:0]  in_axi_awlenw;
    logic        in_axi_awvalid;
    logic        in_axi_awready;
    logic [15:0] in_axi_wdata;
    logic        in_axi_wlast;
    logic        in_axi_wvalid;
    logic        in_axi_wready;
    logic [1:0]  in_axi_bresp;
    logic        in_axi_bvalid;
    logic        in_axi_bready;
    logic [19:0] out_axi_awaddr;
    logic        out_axi_awvalid;
    logic        out_axi_awready = 1'b0;
    logic [15:0] out_axi_wdata;
    logic        out_axi_wvalid;
    logic        out_axi_wready = 1'b0;
    logic [1:0]  out_axi_bresp = 2'b00;
    logic        out_axi_bvalid = 1'b0;
    logic        out_axi_bready;

    axi_writen dut (
        .axi_clk         (axi_clk),
        .axi_resetn      (axi_resetn),
        .in_axi_awaddr   (in_axi_awaddr),
        .in_axi_awlenw   (in_axi_awlenw),
        .in_axi_awvalid  (in_axi_awvalid),
        .in_axi_awready  (in_axi_awready),
        .in_axi_wdata    (in_axi_wdata),
        .in_axi_wlast    (in_axi_wlast),
        .in_axi_wvalid   (in_axi_wvalid),
        .in_axi_wready   (in_axi_wready),
        .in_axi_bresp    (in_axi_bresp),
        .in_axi_bvalid   (in_axi_bvalid),
        .in_axi_bready   (in_axi_bready),
        .out_axi_awaddr  (out_axi_awaddr),
        .out_axi_awvalid (out_axi_awvalid),
        .out_axi_awready (out_axi_awready),
        .out_axi_wdata   (out_axi_wdata),
        .out_axi_wvalid  (out_axi_wvalid),
        .out_axi_wready  (out_axi_wready),
        .out_axi_bresp   (out_axi_bresp),
        .out_axi_bvalid  (out_axi_bvalid),
        .out_axi_bready  (out_axi_bready)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int         due;
        logic [1:0] resp;
    } b_t;

    wr_t         exp_q[$];
    logic [19:0] awq[$];
    logic [15:0] wq[$];
    b_t          bq[$];
    int          pair_cyc[$];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int aw_delay = 0;
    int w_delay = 0;
    int b_delay = 0;
    int aw_cnt = 0;
    int w_cnt = 0;
    int err_abs = -1;
    int pair_count = 0;
    int tb_out = 0;
    int max_out = 0;
    int last_b_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timeout waiting for handshake", tag);
    endtask

    task automatic wait_cycle;
        @(negedge axi_clk);
        #1;
    endtask

    // Subordinate: readies after a per-channel delay, responses after b_delay
    always @(negedge axi_clk) begin
        cyc             <= cyc + 1;
        out_axi_awready <= out_axi_awvalid && (aw_cnt >= aw_delay);
        out_axi_wready  <= out_axi_wvalid && (w_cnt >= w_delay);
        if (bq.size() > 0 && bq[0].due <= cyc) begin
            out_axi_bvalid <= 1'b1;
            out_axi_bresp  <= bq[0].resp;
        end else begin
            out_axi_bvalid <= 1'b0;
            out_axi_bresp  <= 2'b00;
        end
    end

    always @(posedge axi_clk) begin
        logic [19:0] pa;
        logic [15:0] pd;
        wr_t         e;
        int          t;
        if (!axi_resetn) begin
            awq.delete();
            wq.delete();
            bq.delete();
            aw_cnt <= 0;
            w_cnt  <= 0;
            tb_out <= 0;
        end else begin
            if (out_axi_awvalid && out_axi_awready) begin
                awq.push_back(out_axi_awaddr);
                aw_cnt <= 0;
            end else if (out_axi_awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (out_axi_wvalid && out_axi_wready) begin
                wq.push_back(out_axi_wdata);
                w_cnt <= 0;
            end else if (out_axi_wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if (awq.size() > 0 && wq.size() > 0) begin
                pa = awq.pop_front();
                pd = wq.pop_front();
                check("sb_depth", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(pa), 32'(e.addr));
                    check("wr_data", 32'(pd), 32'(e.data));
                end
                bq.push_back('{due: cyc + b_delay,
                               resp: (pair_count == err_abs) ? 2'b10 : 2'b00});
                pair_cyc.push_back(cyc);
                pair_count <= pair_count + 1;
            end
            if (out_axi_bvalid && out_axi_bready) begin
                void'(bq.pop_front());
                last_b_cyc <= cyc;
            end
            t = tb_out + int'(in_axi_wvalid && in_axi_wready)
                       - int'(out_axi_bvalid && out_axi_bready);
            tb_out <= t;
            if (t > max_out) max_out <= t;
        end
    end

    task automatic check_rst(input string p);
        check({p, "_awready"}, 32'(in_axi_awready), 0);
        check({p, "_wready"}, 32'(in_axi_wready), 0);
        check({p, "_bvalid"}, 32'(in_axi_bvalid), 0);
        check({p, "_bresp"}, 32'(in_axi_bresp), 0);
        check({p, "_awvalid"}, 32'(out_axi_awvalid), 0);
        check({p, "_wvalid"}, 32'(out_axi_wvalid), 0);
        check({p, "_awaddr"}, 32'(out_axi_awaddr), 0);
        check({p, "_wdata"}, 32'(out_axi_wdata), 0);
        check({p, "_bready"}, 32'(out_axi_bready), 1);
    endtask

    task automatic burst(input logic [19:0] a, input int len,
                         input logic [15:0] d0, input int err_b,
                         input int wlast_at);
        int         t;
        int         bv_cyc;
        logic [1:0] exp_resp;
        err_abs = (err_b < 0) ? -1 : pair_count + err_b;
`ifdef AXI_WRITEN_RESP_ERR_EN
        exp_resp = ((err_b >= 0 && err_b <= len) || wlast_at != len) ?
                   2'b10 : 2'b00;
`else
        exp_resp = 2'b00;
`endif
        in_axi_awaddr  = a;
        in_axi_awlenw  = 8'(len);
        in_axi_awvalid = 1'b1;
        t = 0;
        while (!in_axi_awready && t < 200) begin
            wait_cycle;
            t++;
        end
        if (t == 200) timeout("aw");
        wait_cycle;
        in_axi_awvalid = 1'b0;
        check("wready_lat", 32'(in_axi_wready), 1);
        for (int i = 0; i <= len; i++) begin
            in_axi_wdata  = d0 + 16'(i);
            in_axi_wlast  = (i == wlast_at);
            in_axi_wvalid = 1'b1;
            exp_q.push_back('{addr: a + 20'(2 * i), data: d0 + 16'(i)});
            t = 0;
            while (!in_axi_wready && t < 200) begin
                wait_cycle;
                t++;
            end
            if (t == 200) timeout("w");
            wait_cycle;
        end
        in_axi_wvalid = 1'b0;
        in_axi_wlast  = 1'b0;
        t = 0;
        while (!in_axi_bvalid && t < 500) begin
            wait_cycle;
            t++;
        end
        if (t == 500) timeout("b");
        bv_cyc = cyc;
        check("bvalid_lat", 32'(bv_cyc - last_b_cyc), 1);
        check("bresp", 32'(in_axi_bresp), 32'(exp_resp));
        in_axi_bready = 1'b1;
        wait_cycle;
        in_axi_bready = 1'b0;
        check("bvalid_drop", 32'(in_axi_bvalid), 0);
        check("awready_back", 32'(in_axi_awready), 1);
        err_abs = -1;
    endtask

    initial begin
        int t;
        axi_resetn     = 1'b0;
        in_axi_awaddr  = '0;
        in_axi_awlenw  = '0;
        in_axi_awvalid = 1'b0;
        in_axi_wdata   = '0;
        in_axi_wlast   = 1'b0;
        in_axi_wvalid  = 1'b0;
        in_axi_bready  = 1'b0;
        repeat (3) wait_cycle;
        check_rst("rst");
        axi_resetn = 1'b1;
        check("awready_rel", 32'(in_axi_awready), 0);
        wait_cycle;
        check("awready_up", 32'(in_axi_awready), 1);

        pair_cyc.delete();
        burst(20'h00100, 3, 16'h00A0, -1, 3);
        check("tput_n", 32'(pair_cyc.size()), 4);
        if (pair_cyc.size() == 4)
            check("tput_span", 32'(pair_cyc[3] - pair_cyc[0]), 3);

        burst(20'h00200, 0, 16'h1111, -1, 0);

        b_delay = 20;
        burst(20'h00300, 7, 16'h2200, -1, 7);
        check("max_outstanding", 32'(max_out), 4);
        b_delay = 0;

        aw_delay = 0;
        w_delay  = 3;
        burst(20'h00400, 3, 16'h3300, -1, 3);
        aw_delay = 3;
        w_delay  = 0;
        burst(20'h00500, 3, 16'h4400, -1, 3);
        aw_delay = 0;
        check("sb_empty_a", 32'(exp_q.size()), 0);

        burst(20'h00600, 3, 16'h5500, 2, 3);
        burst(20'h00700, 3, 16'h6600, -1, 0);

        burst(20'hFFFFC, 3, 16'h7700, -1, 3);
        burst(20'h00800, 255, 16'h8000, -1, 255);

        in_axi_awaddr  = 20'h00040;
        in_axi_awlenw  = 8'd7;
        in_axi_awvalid = 1'b1;
        t = 0;
        while (!in_axi_awready && t < 200) begin
            wait_cycle;
            t++;
        end
        if (t == 200) timeout("rst_aw");
        wait_cycle;
        in_axi_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_axi_wdata  = 16'h9900 + 16'(i);
            in_axi_wvalid = 1'b1;
            exp_q.push_back('{addr: 20'h00040 + 20'(2 * i),
                              data: 16'h9900 + 16'(i)});
            t = 0;
            while (!in_axi_wready && t < 200) begin
                wait_cycle;
                t++;
            end
            if (t == 200) timeout("rst_w");
            wait_cycle;
        end
        in_axi_wdata = 16'h9902;
        axi_resetn   = 1'b0;
        #1;
        check_rst("mid");
        in_axi_wvalid = 1'b0;
        exp_q.delete();
        repeat (2) wait_cycle;
        axi_resetn = 1'b1;
        wait_cycle;
        check("awready_rst2", 32'(in_axi_awready), 1);
        burst(20'h00000, 3, 16'hB000, -1, 3);

        repeat (5) wait_cycle;
        check("sb_empty_end", 32'(exp_q.size()), 0);
        check("outstanding_end", 32'(tb_out), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
